// File: rtl/gate_input_debounce_pkg.sv
// Shared definitions for the gate input debounce stage: per-channel FSM
// state encoding and default debounce constants reused by other board-input
// conditioning blocks.
package gate_input_debounce_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_W         = 20;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional two-flop synchroniser, sample flop,
// stability counter, two-state FSM, output flop and a one-cycle toggled flag.
// Optional synchroniser selected by macro GATE_DEBOUNCE_SYNC_EN.
module debounce_channel
  import gate_input_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_out,
  output logic o_toggled
);

  // Counter value at which a pending level has persisted long enough.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_in;
  logic             r_s;
  logic             r_out;
  logic             r_toggled;
  logic [CNT_W-1:0] r_cnt;
  deb_state_e       r_state;

  logic             w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  deb_state_e       w_state_nxt;

`ifdef GATE_DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchroniser for a fully asynchronous raw input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_raw};
  end

  assign w_in = r_sync[1];
`else
  assign w_in = i_raw;
`endif

  // Sample flop: captures the (possibly synchronised) raw level every edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_s <= 1'b0;
    else          r_s <= w_in;
  end

  // Next-state logic: count while the sample differs from the output,
  // commit after STABLE_CYCLES consecutive differing samples, drop glitches.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      ST_STABLE: begin
        w_cnt_nxt = '0;
        if (r_s != r_out) begin
          // A one-cycle window commits straight from STABLE.
          if (r_cnt == LP_LAST) begin
            w_out_nxt = r_s;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (r_s == r_out) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == LP_LAST) begin
          w_out_nxt   = r_s;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

  // FSM, counter, output and toggled-flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_toggled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out     <= w_out_nxt;
      r_toggled <= (w_out_nxt != r_out);
    end
  end

  assign o_out     = r_out;
  assign o_toggled = r_toggled;

endmodule

// File: rtl/gate_input_debounce.sv
// Two-channel input conditioning stage feeding the A/B inputs of the
// two-input gates. Each channel is debounced independently; CHG is a single
// registered pulse one cycle after either (or both) outputs changed.
// Optional input synchroniser selected by macro GATE_DEBOUNCE_SYNC_EN.
module gate_input_debounce
  import gate_input_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic RAW_A,
  input  logic RAW_B,
  output logic A,
  output logic B,
  output logic CHG
);

  logic w_tog_a;
  logic w_tog_b;
  logic r_chg;

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_raw     (RAW_A),
    .o_out     (A),
    .o_toggled (w_tog_a)
  );

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_raw     (RAW_B),
    .o_out     (B),
    .o_toggled (w_tog_b)
  );

  // Merge both toggled flags so simultaneous changes give one pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_chg <= 1'b0;
    else        r_chg <= w_tog_a | w_tog_b;
  end

  assign CHG = r_chg;

endmodule

// File: tb/tb_gate_input_debounce.sv
// Directed testbench for gate_input_debounce with STABLE_CYCLES = 4.
// Inputs change on the falling edge; outputs are checked on the following
// falling edge, i.e. half a cycle after the rising edge that updated them.
module tb_gate_input_debounce;

  localparam int N = 4;
`ifdef GATE_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NV = 37;

  // {raw_a, raw_b, exp_a, exp_b, exp_chg}
  typedef struct packed {
    logic raw_a;
    logic raw_b;
    logic exp_a;
    logic exp_b;
    logic exp_chg;
  } vec_t;

  logic CLK;
  logic RST_N;
  logic RAW_A;
  logic RAW_B;
  logic A;
  logic B;
  logic CHG;

  int n_cmp;
  int n_err;
  vec_t vec[NV];

  gate_input_debounce #(
    .STABLE_CYCLES (N),
    .CNT_W         (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RAW_A (RAW_A),
    .RAW_B (RAW_B),
    .A     (A),
    .B     (B),
    .CHG   (CHG)
  );

  // Clock: 10 ns period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Compare {A,B,CHG} with the expected triple.
  task automatic check(input string name, input int idx, input logic [2:0] exp);
    logic [2:0] act;
    act = {A, B, CHG};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got A,B,CHG=%b expected %b at %0t", name, idx, act, exp, $time);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Clean edge on A.
    vec[0]  = 5'b10000; vec[1]  = 5'b10000; vec[2]  = 5'b10000; vec[3]  = 5'b10000;
    vec[4]  = 5'b10100; vec[5]  = 5'b10101; vec[6]  = 5'b10100;
    // Glitch on B: three samples high, then low.
    vec[7]  = 5'b11100; vec[8]  = 5'b11100; vec[9]  = 5'b11100; vec[10] = 5'b10100;
    vec[11] = 5'b10100; vec[12] = 5'b10100; vec[13] = 5'b10100;
    // A falls back to 0.
    vec[14] = 5'b00100; vec[15] = 5'b00100; vec[16] = 5'b00100; vec[17] = 5'b00100;
    vec[18] = 5'b00000; vec[19] = 5'b00001; vec[20] = 5'b00000;
    // Simultaneous rise: one CHG pulse.
    vec[21] = 5'b11000; vec[22] = 5'b11000; vec[23] = 5'b11000; vec[24] = 5'b11000;
    vec[25] = 5'b11110; vec[26] = 5'b11111; vec[27] = 5'b11110; vec[28] = 5'b11110;
    // Staggered fall: back-to-back CHG pulses.
    vec[29] = 5'b01110; vec[30] = 5'b00110; vec[31] = 5'b00110; vec[32] = 5'b00110;
    vec[33] = 5'b00010; vec[34] = 5'b00001; vec[35] = 5'b00001; vec[36] = 5'b00000;

    // Reset held with raw inputs high: everything stays 0.
    RST_N = 1'b0;
    RAW_A = 1'b1;
    RAW_B = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("in_reset", k, 3'b000);
    end

    // Release: both outputs rise N edges after the first sampling edge.
    RST_N = 1'b1;
    for (int k = 0; k <= LAT + N + 2; k++) begin
      tick();
      check("after_release", k,
            {(k >= LAT + N) ? 2'b11 : 2'b00, (k == LAT + N + 1) ? 1'b1 : 1'b0});
    end

    // Asynchronous clear of set outputs.
    RST_N = 1'b0;
    #1;
    check("async_clear", 0, 3'b000);
    RAW_A = 1'b1;
    RAW_B = 1'b0;
    tick();
    RST_N = 1'b1;

    // Count to 2 on A, then reset mid-count.
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      check("midcnt_run", k, 3'b000);
    end
    RST_N = 1'b0;
    #1;
    check("midcnt_rst", 0, 3'b000);
    tick();
    check("midcnt_hold", 0, 3'b000);
    RST_N = 1'b1;
    for (int k = 0; k <= LAT + N + 2; k++) begin
      tick();
      check("midcnt_restart", k,
            {(k >= LAT + N) ? 1'b1 : 1'b0, 1'b0, (k == LAT + N + 1) ? 1'b1 : 1'b0});
    end

    // Clean start for the vector table.
    RST_N = 1'b0;
    RAW_A = 1'b0;
    RAW_B = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    check("idle", 0, 3'b000);

    // Apply table; with the synchroniser, outputs lag the table by LAT rows.
    for (int i = 0; i < NV + LAT; i++) begin
      int   in_idx;
      vec_t ev;
      in_idx = (i < NV) ? i : NV - 1;
      RAW_A  = vec[in_idx].raw_a;
      RAW_B  = vec[in_idx].raw_b;
      ev     = (i >= LAT) ? vec[i - LAT] : 5'b00000;
      tick();
      check("vec", i, {ev.exp_a, ev.exp_b, ev.exp_chg});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
